// File: rtl/three_phase_lut_sequencer.sv
// Three-phase sine sequencer: one LUT port time-shared by phases A/B/C,
// three reads per sample tick, outputs updated together with a valid pulse.
module three_phase_lut_sequencer #(
    parameter int unsigned DIV       = 12,
    parameter int unsigned LUT_DEPTH = 9999,
    parameter int unsigned AW        = 14,
    parameter int unsigned DW        = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          restart,
    output logic          lut_rd,
    output logic [AW-1:0] lut_addr,
    input  logic [DW-1:0] lut_data,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_c,
    output logic          sample_valid,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        RD_C  = 3'd3,
        CAP_C = 3'd4
    } state_t;

    localparam logic [15:0]   DIV_LAST = 16'(DIV - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(LUT_DEPTH - 1);
    localparam logic [AW-1:0] PTR_A0   = '0;
    localparam logic [AW-1:0] PTR_B0   = AW'(LUT_DEPTH / 3);
    localparam logic [AW-1:0] PTR_C0   = AW'((2 * LUT_DEPTH) / 3);

    state_t        state_q, state_d;
    logic [15:0]   div_q, div_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] ptr_a_q, ptr_a_d;
    logic [AW-1:0] ptr_b_q, ptr_b_d;
    logic [AW-1:0] ptr_c_q, ptr_c_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] sh_a_q, sh_a_d;
    logic [DW-1:0] sh_b_q, sh_b_d;
    logic [DW-1:0] sh_c_q, sh_c_d;
    logic [DW-1:0] out_a_q, out_a_d;
    logic [DW-1:0] out_b_q, out_b_d;
    logic [DW-1:0] out_c_q, out_c_d;
    logic          sv_q, sv_d;
    logic          tick;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign tick = en && (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        pend_d   = pend_q;
        ptr_a_d  = ptr_a_q;
        ptr_b_d  = ptr_b_q;
        ptr_c_d  = ptr_c_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        sh_c_d   = sh_c_q;
        out_a_d  = out_a_q;
        out_b_d  = out_b_q;
        out_c_d  = out_c_q;
        sv_d     = 1'b0;
        lut_rd   = 1'b0;
        lut_addr = addr_q;

        if (!en || div_q == DIV_LAST) div_d = '0;
        else                          div_d = div_q + 16'd1;

        case (state_q)
            IDLE: if (tick) state_d = RD_A;
            RD_A: begin
                state_d  = RD_B;
                lut_rd   = 1'b1;
                lut_addr = ptr_a_q;
            end
            RD_B: begin
                state_d  = RD_C;
                lut_rd   = 1'b1;
                lut_addr = ptr_b_q;
                sh_a_d   = lut_data;
            end
            RD_C: begin
                state_d  = CAP_C;
                lut_rd   = 1'b1;
                lut_addr = ptr_c_q;
                sh_b_d   = lut_data;
            end
            CAP_C: begin
                state_d = IDLE;
                sh_c_d  = lut_data;
                // C arrives on this same edge, so it bypasses its shadow
                out_a_d = sh_a_q;
                out_b_d = sh_b_q;
                out_c_d = lut_data;
                sv_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == CAP_C) begin
            pend_d = 1'b0;
            if (pend_q || restart) begin
                ptr_a_d = PTR_A0;
                ptr_b_d = PTR_B0;
                ptr_c_d = PTR_C0;
            end else begin
                ptr_a_d = ptr_inc(ptr_a_q);
                ptr_b_d = ptr_inc(ptr_b_q);
                ptr_c_d = ptr_inc(ptr_c_q);
            end
        end else if (restart) begin
            // Idle with no tick: reload now; otherwise defer to the sequence end
            if (state_q == IDLE && !tick) begin
                ptr_a_d = PTR_A0;
                ptr_b_d = PTR_B0;
                ptr_c_d = PTR_C0;
                pend_d  = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            pend_q  <= 1'b0;
            ptr_a_q <= PTR_A0;
            ptr_b_q <= PTR_B0;
            ptr_c_q <= PTR_C0;
            addr_q  <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_c_q  <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            out_c_q <= '0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            ptr_a_q <= ptr_a_d;
            ptr_b_q <= ptr_b_d;
            ptr_c_q <= ptr_c_d;
            addr_q  <= lut_addr;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_c_q  <= sh_c_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            out_c_q <= out_c_d;
            sv_q    <= sv_d;
        end
    end

    assign out_a        = out_a_q;
    assign out_b        = out_b_q;
    assign out_c        = out_c_q;
    assign sample_valid = sv_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_three_phase_lut_sequencer.sv
// Bench for three_phase_lut_sequencer: directed scenarios plus random enable
// traffic, checked against a phase-pointer/LUT reference model.
module tb_three_phase_lut_sequencer;

    localparam int D = 12;

    logic        clk = 1'b0;
    logic        rst, en, restart;
    logic        lut_rd, sample_valid, busy;
    logic [3:0]  lut_addr;
    logic [11:0] lut_data;
    logic [11:0] out_a, out_b, out_c;

    int          errs = 0;
    int          chks = 0;
    logic [11:0] mem [D];

    int          m_ptr = 0;
    bit          m_pend = 0;
    logic [11:0] exp_a = '0, exp_b = '0, exp_c = '0;
    int          rd_idx = 0;
    bit          prev_sv = 0;
    int          sv_count = 0;

    three_phase_lut_sequencer #(.DIV(6), .LUT_DEPTH(12), .AW(4), .DW(12)) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .lut_rd(lut_rd), .lut_addr(lut_addr), .lut_data(lut_data),
        .out_a(out_a), .out_b(out_b), .out_c(out_c),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lut_rd) lut_data <= (int'(lut_addr) < D) ? mem[lut_addr] : 12'hbad;
    end

    // Reference model: phase A pointer, B/C at +D/3 and +2D/3
    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_ptr = 0; m_pend = 0; rd_idx = 0; prev_sv = 0;
            exp_a = '0; exp_b = '0; exp_c = '0;
        end else begin
            if (lut_rd) begin
                chks++;
                if (int'(lut_addr) != (m_ptr + rd_idx * (D / 3)) % D) begin
                    errs++;
                    $display("FAIL bus_addr: got %0d expected %0d (read %0d)",
                             lut_addr, (m_ptr + rd_idx * (D / 3)) % D, rd_idx);
                end
                rd_idx++;
            end else begin
                if (rd_idx != 0) begin
                    chks++;
                    if (rd_idx != 3) begin
                        errs++;
                        $display("FAIL bus_len: got %0d reads expected 3", rd_idx);
                    end
                end
                rd_idx = 0;
            end
            if (sample_valid) begin
                chks++;
                if (prev_sv) begin
                    errs++;
                    $display("FAIL sv_width: got 2-cycle pulse expected 1");
                end
                exp_a = mem[m_ptr];
                exp_b = mem[(m_ptr + D / 3) % D];
                exp_c = mem[(m_ptr + 2 * D / 3) % D];
                m_ptr = m_pend ? 0 : (m_ptr + 1) % D;
                m_pend = 0;
                sv_count++;
            end
            chks++;
            if (out_a !== exp_a || out_b !== exp_b || out_c !== exp_c) begin
                errs++;
                $display("FAIL outs: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         out_a, out_b, out_c, exp_a, exp_b, exp_c);
            end
            prev_sv = sample_valid;
        end
    end

    task automatic wait_sv(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget && n < 0; k++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) n = k;
        end
    endtask

    task automatic wait_rd(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget && n < 0; k++) begin
            @(negedge clk);
            if (lut_rd === 1'b1) n = k;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; restart = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < D; i++) mem[i] = 12'(i * 5);
        rst = 1'b1; en = 1'b1; restart = 1'b1;
        repeat (3) @(negedge clk);
        chks++;
        if (lut_rd !== 1'b0 || lut_addr !== 4'd0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctl: got rd=%b addr=%0d busy=%b sv=%b expected 0/0/0/0",
                     lut_rd, lut_addr, busy, sample_valid);
        end
        chks++;
        if (out_a !== 12'd0 || out_b !== 12'd0 || out_c !== 12'd0) begin
            errs++;
            $display("FAIL reset_outs: got %0d/%0d/%0d expected 0/0/0", out_a, out_b, out_c);
        end
        restart = 1'b0;
    endtask

    task automatic test_cadence();
        int n;
        rst = 1'b0; en = 1'b1;
        wait_sv(40, n);
        chks++;
        if (n != 10) begin errs++; $display("FAIL first_latency: got %0d expected 10", n); end
        chks++;
        if (out_a !== 12'd0 || out_b !== 12'd20 || out_c !== 12'd40) begin
            errs++;
            $display("FAIL sample1: got %0d/%0d/%0d expected 0/20/40", out_a, out_b, out_c);
        end
        wait_sv(40, n);
        chks++;
        if (n != 6) begin errs++; $display("FAIL period: got %0d expected 6", n); end
        chks++;
        if (out_a !== 12'd5 || out_b !== 12'd25 || out_c !== 12'd45) begin
            errs++;
            $display("FAIL sample2: got %0d/%0d/%0d expected 5/25/45", out_a, out_b, out_c);
        end
    endtask

    task automatic test_wrap();
        int n;
        for (int s = 3; s <= 11; s++) wait_sv(40, n);
        wait_sv(40, n);
        chks++;
        if (n != 6 || out_a !== 12'd55 || out_b !== 12'd15 || out_c !== 12'd35) begin
            errs++;
            $display("FAIL sample12: got %0d/%0d/%0d gap %0d expected 55/15/35 gap 6",
                     out_a, out_b, out_c, n);
        end
        wait_sv(40, n);
        chks++;
        if (out_a !== 12'd0 || out_b !== 12'd20 || out_c !== 12'd40) begin
            errs++;
            $display("FAIL sample13: got %0d/%0d/%0d expected 0/20/40", out_a, out_b, out_c);
        end
    endtask

    task automatic test_restart_busy();
        int n;
        do_reset();
        for (int s = 0; s < 3; s++) wait_sv(40, n);
        wait_rd(40, n);
        @(negedge clk);
        restart = 1'b1; m_pend = 1;
        @(negedge clk);
        restart = 1'b0;
        wait_sv(40, n);
        chks++;
        if (n != 2 || out_a !== 12'd15 || out_b !== 12'd35 || out_c !== 12'd55) begin
            errs++;
            $display("FAIL restart_same: got %0d/%0d/%0d at +%0d expected 15/35/55 at +2",
                     out_a, out_b, out_c, n);
        end
        wait_sv(40, n);
        chks++;
        if (out_a !== 12'd0 || out_b !== 12'd20 || out_c !== 12'd40) begin
            errs++;
            $display("FAIL restart_next: got %0d/%0d/%0d expected 0/20/40", out_a, out_b, out_c);
        end
    endtask

    task automatic test_restart_idle();
        int n;
        for (int s = 0; s < 4; s++) wait_sv(40, n);
        en = 1'b0;
        repeat (3) @(negedge clk);
        restart = 1'b1; m_ptr = 0;
        @(negedge clk);
        restart = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        wait_sv(40, n);
        chks++;
        if (n != 10 || out_a !== 12'd0 || out_b !== 12'd20 || out_c !== 12'd40) begin
            errs++;
            $display("FAIL restart_idle: got %0d/%0d/%0d at +%0d expected 0/20/40 at +10",
                     out_a, out_b, out_c, n);
        end
    endtask

    task automatic test_en_drop();
        int  n;
        bit  seen;
        wait_rd(40, n);
        en = 1'b0;
        wait_sv(40, n);
        chks++;
        if (n != 4) begin errs++; $display("FAIL endrop_sv: got +%0d expected +4", n); end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (lut_rd !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0) seen = 1;
        end
        chks++;
        if (seen) begin errs++; $display("FAIL endrop_quiet: got activity expected none"); end
        en = 1'b1;
        wait_rd(40, n);
        chks++;
        if (n != 6) begin errs++; $display("FAIL reenable_tick: got +%0d expected +6", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        wait_rd(40, n);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chks++;
        if (busy !== 1'b0 || lut_rd !== 1'b0 || sample_valid !== 1'b0 ||
            out_a !== 12'd0 || out_b !== 12'd0 || out_c !== 12'd0) begin
            errs++;
            $display("FAIL reset_mid: got busy=%b rd=%b sv=%b outs=%0d/%0d/%0d expected all 0",
                     busy, lut_rd, sample_valid, out_a, out_b, out_c);
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (sample_valid !== 1'b0 || lut_rd !== 1'b0) seen = 1;
        end
        chks++;
        if (seen) begin errs++; $display("FAIL reset_mid_tail: got activity expected none"); end
    endtask

    task automatic test_random();
        int start;
        rst = 1'b1; en = 1'b0; restart = 1'b0;
        for (int i = 0; i < D; i++) mem[i] = 12'($urandom_range(0, 4095));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start = sv_count;
        for (int seg = 0; seg < 60; seg++) begin
            en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 15)) @(negedge clk);
        end
        en = 1'b0;
        repeat (10) @(negedge clk);
        chks++;
        if (sv_count - start < 5) begin
            errs++;
            $display("FAIL random_samples: got %0d samples expected at least 5", sv_count - start);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; restart = 1'b0;
        @(negedge clk);
        test_reset();
        test_cadence();
        test_wrap();
        test_restart_busy();
        test_restart_idle();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
